// File: rtl/logical_op_sequencer.sv
// Slice-serial logical unit: reduces each operand to an "any bit set" flag N bits per cycle,
// combines the flags with the requested op, and stops as soon as the answer is decided.
module logical_op_sequencer #(
  parameter int W = 32,
  parameter int N = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [W-1:0]                in_a,
  input  logic [W-1:0]                in_b,
  input  logic [1:0]                  in_op,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_c,
  output logic [$clog2(W/N+1)-1:0]    out_slices,
  output logic [1:0]                  dbg_state
);
  localparam int S  = W / N;
  localparam int CW = $clog2(S + 1);
  localparam int IW = (S > 1) ? $clog2(S) : 1;

  localparam logic [1:0] OP_LAND  = 2'b00;
  localparam logic [1:0] OP_LOR   = 2'b01;
  localparam logic [1:0] OP_LXOR  = 2'b10;
  localparam logic [1:0] OP_LNAND = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, EVAL = 2'd1, DONE = 2'd2} state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [1:0]      r_op;
  logic            r_acc_a;
  logic            r_acc_b;
  logic [IW-1:0]   r_idx;
  logic            r_out_valid;
  logic            r_out_c;
  logic [CW-1:0]   r_out_slices;

  logic            w_na;
  logic            w_nb;
  logic            w_last;
  logic            w_early;
  logic            w_result;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready is only high in IDLE (and low during reset); out_valid only in DONE.
  assign in_ready   = rst_n && (r_state == IDLE);
  assign out_valid  = r_out_valid;
  assign out_c      = r_out_c;
  assign out_slices = r_out_slices;
  assign dbg_state  = r_state;

  // Operand registers shift right each EVAL cycle, so the current slice is always bits [N-1:0].
  assign w_na   = r_acc_a | (|r_a[N-1:0]);
  assign w_nb   = r_acc_b | (|r_b[N-1:0]);
  assign w_last = (r_idx == IW'(S - 1));

  always_comb begin
    w_early  = 1'b0;
    w_result = 1'b0;
    case (r_op)
      OP_LAND: begin
        w_early  = w_na && w_nb;
        w_result = w_na & w_nb;
      end
      OP_LOR: begin
        w_early  = w_na || w_nb;
        w_result = w_na | w_nb;
      end
      OP_LXOR: begin
        w_early  = 1'b0;
        w_result = w_na ^ w_nb;
      end
      default: begin
        w_early  = w_na && w_nb;
        w_result = ~(w_na & w_nb);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_acc_a      <= 1'b0;
      r_acc_b      <= 1'b0;
      r_idx        <= '0;
      r_out_valid  <= 1'b0;
      r_out_c      <= 1'b0;
      r_out_slices <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_op    <= in_op;
            r_acc_a <= 1'b0;
            r_acc_b <= 1'b0;
            r_idx   <= '0;
            r_state <= EVAL;
          end
        end
        EVAL: begin
          r_acc_a <= w_na;
          r_acc_b <= w_nb;
          r_a     <= r_a >> N;
          r_b     <= r_b >> N;
          if (w_last || w_early) begin
            r_out_c      <= w_result;
            r_out_slices <= CW'(r_idx) + CW'(1);
            r_out_valid  <= 1'b1;
            r_state      <= DONE;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_logical_op_sequencer.sv
// Directed bench for logical_op_sequencer (W=32, N=8, S=4) with hand-computed expectations.
module tb_logical_op_sequencer;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic        out_c;
  logic [2:0]  out_slices;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logical_op_sequencer #(.W(32), .N(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_slices(out_slices),
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one edge; reports whether in_ready was high at that edge.
  task automatic accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output bit rdy);
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    rdy      = in_ready;
    step();
    in_valid = 1'b0;
  endtask

  // Counts edges until out_valid (bounded at 20); notes any in_ready seen on the way.
  task automatic wait_valid(output int lat, output bit saw_ready);
    lat = 0;
    saw_ready = 1'b0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
      if (in_ready) saw_ready = 1'b1;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_c !== 1'b0) begin errors++; $display("FAIL reset_out_c got=%b exp=0", out_c); end
    checks++; if (out_slices !== 3'd0) begin errors++; $display("FAIL reset_out_slices got=%0d exp=0", out_slices); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_land();
    int lat; bit rdy; bit saw;
    accept(2'b00, 32'h0000_00FF, 32'h0000_0001, rdy);
    wait_valid(lat, saw);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL land_early_accept got=%b exp=1", rdy); end
    checks++; if (lat != 1) begin errors++; $display("FAIL land_early_latency got=%0d exp=1", lat); end
    checks++; if (out_c !== 1'b1 || out_slices !== 3'd1) begin errors++; $display("FAIL land_early_result got=%b/%0d exp=1/1", out_c, out_slices); end
    release_result();

    accept(2'b00, 32'h0000_0100, 32'h8000_0000, rdy);
    wait_valid(lat, saw);
    checks++; if (lat != 4) begin errors++; $display("FAIL land_full_latency got=%0d exp=4", lat); end
    checks++; if (out_c !== 1'b1 || out_slices !== 3'd4) begin errors++; $display("FAIL land_full_result got=%b/%0d exp=1/4", out_c, out_slices); end
    checks++; if (saw !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL land_full_in_ready got=%b/%b exp=0/0", saw, in_ready); end
    release_result();
  endtask

  task automatic test_zero_operand();
    int lat; bit rdy; bit saw;
    accept(2'b00, 32'h0, 32'hFFFF_FFFF, rdy);
    wait_valid(lat, saw);
    checks++; if (lat != 4 || out_c !== 1'b0 || out_slices !== 3'd4) begin errors++; $display("FAIL land_zero_a got=%0d/%b/%0d exp=4/0/4", lat, out_c, out_slices); end
    release_result();
    accept(2'b11, 32'h0, 32'hFFFF_FFFF, rdy);
    wait_valid(lat, saw);
    checks++; if (lat != 4 || out_c !== 1'b1 || out_slices !== 3'd4) begin errors++; $display("FAIL lnand_zero_a got=%0d/%b/%0d exp=4/1/4", lat, out_c, out_slices); end
    release_result();
    accept(2'b01, 32'h0, 32'h0, rdy);
    wait_valid(lat, saw);
    checks++; if (lat != 4 || out_c !== 1'b0 || out_slices !== 3'd4) begin errors++; $display("FAIL lor_all_zero got=%0d/%b/%0d exp=4/0/4", lat, out_c, out_slices); end
    release_result();
    accept(2'b11, 32'h0000_00FF, 32'h0000_00FF, rdy);
    wait_valid(lat, saw);
    checks++; if (lat != 1 || out_c !== 1'b0 || out_slices !== 3'd1) begin errors++; $display("FAIL lnand_early got=%0d/%b/%0d exp=1/0/1", lat, out_c, out_slices); end
    release_result();
  endtask

  task automatic test_lor_lxor();
    int lat; bit rdy; bit saw;
    accept(2'b01, 32'h0000_0001, 32'h0, rdy);
    wait_valid(lat, saw);
    checks++; if (lat != 1 || out_c !== 1'b1 || out_slices !== 3'd1) begin errors++; $display("FAIL lor_early got=%0d/%b/%0d exp=1/1/1", lat, out_c, out_slices); end
    release_result();
    accept(2'b10, 32'h0000_0010, 32'h0, rdy);
    wait_valid(lat, saw);
    checks++; if (lat != 4 || out_c !== 1'b1 || out_slices !== 3'd4) begin errors++; $display("FAIL lxor_one got=%0d/%b/%0d exp=4/1/4", lat, out_c, out_slices); end
    release_result();
    accept(2'b10, 32'h0000_0001, 32'h0100_0000, rdy);
    wait_valid(lat, saw);
    checks++; if (lat != 4 || out_c !== 1'b0 || out_slices !== 3'd4) begin errors++; $display("FAIL lxor_both got=%0d/%b/%0d exp=4/0/4", lat, out_c, out_slices); end
    release_result();
  endtask

  task automatic test_backpressure();
    int lat; bit rdy; bit saw; bit ok;
    accept(2'b01, 32'h0000_0001, 32'h0, rdy);
    wait_valid(lat, saw);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      in_a     = $urandom_range(0, 32'h7FFF_FFFF);
      in_b     = $urandom_range(0, 32'h7FFF_FFFF);
      in_op    = 2'(i);
      step();
      if (out_valid !== 1'b1 || out_c !== 1'b1 || out_slices !== 3'd1 || in_ready !== 1'b0) ok = 1'b0;
    end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL backpressure_hold got=%b/%b/%0d exp=1/1/1", out_valid, out_c, out_slices); end
    in_valid = 1'b0;
    release_result();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL backpressure_release got=%b/%b exp=0/1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    int lat; bit rdy; bit saw;
    accept(2'b00, 32'h0000_FF00, 32'h0000_0100, rdy);
    wait_valid(lat, saw);
    checks++; if (rdy !== 1'b1 || lat != 2 || out_c !== 1'b1 || out_slices !== 3'd2) begin errors++; $display("FAIL b2b_first got=%b/%0d/%b/%0d exp=1/2/1/2", rdy, lat, out_c, out_slices); end
    release_result();
    accept(2'b01, 32'h0, 32'h0001_0000, rdy);
    wait_valid(lat, saw);
    checks++; if (rdy !== 1'b1 || lat != 3 || out_c !== 1'b1 || out_slices !== 3'd3) begin errors++; $display("FAIL b2b_second got=%b/%0d/%b/%0d exp=1/3/1/3", rdy, lat, out_c, out_slices); end
    release_result();
  endtask

  task automatic test_reset_mid_eval();
    int lat; bit rdy; bit saw;
    accept(2'b10, 32'h0000_0010, 32'h0, rdy);
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_c !== 1'b0 || out_slices !== 3'd0) begin errors++; $display("FAIL mid_reset_outputs got=%b/%b/%0d exp=0/0/0", out_valid, out_c, out_slices); end
    checks++; if (in_ready !== 1'b1 || dbg_state !== 2'd0) begin errors++; $display("FAIL mid_reset_idle got=%b/%0d exp=1/0", in_ready, dbg_state); end
    accept(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rdy);
    wait_valid(lat, saw);
    checks++; if (lat != 1 || out_c !== 1'b1 || out_slices !== 3'd1) begin errors++; $display("FAIL mid_reset_next got=%0d/%b/%0d exp=1/1/1", lat, out_c, out_slices); end
    release_result();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    out_ready = 1'b0;
    test_reset();
    test_land();
    test_zero_operand();
    test_lor_lxor();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_eval();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
